// File: rtl/cpu_pkg.sv
// Shared types and defaults for the 8-bit CPU sequencer: state encoding,
// opcode classes and the helper that classifies an instruction byte.
package cpu_pkg;

  localparam int ADDR_W_DEFAULT  = 8;
  localparam int TIMEOUT_DEFAULT = 15;

  typedef enum logic [2:0] {
    FETCH,
    WAIT,
    DECODE,
    EXEC,
    HALT,
    FAULT
  } seq_state_t;

  typedef enum logic [1:0] {
    OP_LOAD,
    OP_ALU,
    OP_COPY,
    OP_COND
  } opcode_t;

  function automatic opcode_t opcodeOf(input logic [7:0] instrByte);
    return opcode_t'(instrByte[7:6]);
  endfunction

endpackage

// File: rtl/instr_sequencer_pc.sv
// Program counter: loads a redirect target or increments with natural
// wrap at 2^ADDR_W; holds otherwise.
module program_counter #(
  parameter int ADDR_W = 8
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              load_i,
  input  logic              inc_i,
  input  logic [ADDR_W-1:0] loadVal_i,
  output logic [ADDR_W-1:0] pc_o
);

  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] pc_d;

  // Load wins over increment so a taken branch never also advances.
  always_comb begin
    pc_d = pc_q;
    if (load_i) begin
      pc_d = loadVal_i;
    end else if (inc_i) begin
      pc_d = pc_q + ADDR_W'(1);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pc_q <= '0;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc_o = pc_q;

endmodule

// File: rtl/instr_sequencer.sv
// Fetch/decode/execute sequencer: fetches one instruction byte per group over
// a req/ack handshake, strobes exec_en for one cycle, and owns PC, halt and fault.
module instr_sequencer
  import cpu_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEFAULT,
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic              clock,
  input  logic              reset_n,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [7:0]        mem_rdata,
  output logic [7:0]        instr,
  output logic              exec_en,
  input  logic              cond_taken,
  input  logic [ADDR_W-1:0] branch_target,
  input  logic              halt_req,
  output logic [ADDR_W-1:0] pc,
  output logic              halted,
  output logic              fault
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

  seq_state_t        state_q;
  logic [CNT_W-1:0]  timeoutCnt_q;
  logic [7:0]        instr_q;
  logic              memReq_q;
  logic              execEn_q;
  logic              halted_q;
  logic              fault_q;

  logic              pcLoad;
  logic              pcInc;
  logic [ADDR_W-1:0] pcValue;

  // The PC only moves at the end of EXEC; everywhere else it is frozen,
  // which also keeps the faulting address visible in FAULT.
  assign pcLoad = (state_q == EXEC) && (opcodeOf(instr_q) == OP_COND) && cond_taken;
  assign pcInc  = (state_q == EXEC) && !pcLoad;

  program_counter #(
    .ADDR_W(ADDR_W)
  ) u_pc (
    .clock    (clock),
    .reset_n  (reset_n),
    .load_i   (pcLoad),
    .inc_i    (pcInc),
    .loadVal_i(branch_target),
    .pc_o     (pcValue)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= FETCH;
      timeoutCnt_q <= '0;
      instr_q      <= 8'h00;
      memReq_q     <= 1'b0;
      execEn_q     <= 1'b0;
      halted_q     <= 1'b0;
      fault_q      <= 1'b0;
    end else begin
      execEn_q <= 1'b0;
      unique case (state_q)
        FETCH: begin
          memReq_q     <= 1'b1;
          timeoutCnt_q <= '0;
          state_q      <= WAIT;
        end
        WAIT: begin
          // An ack on the last allowed cycle still wins over the timeout.
          if (mem_ack) begin
            instr_q      <= mem_rdata;
            memReq_q     <= 1'b0;
            timeoutCnt_q <= '0;
            state_q      <= DECODE;
          end else if (timeoutCnt_q == (TIMEOUT_C - CNT_W'(1))) begin
            memReq_q     <= 1'b0;
            fault_q      <= 1'b1;
            timeoutCnt_q <= TIMEOUT_C;
            state_q      <= FAULT;
          end else begin
            timeoutCnt_q <= timeoutCnt_q + CNT_W'(1);
          end
        end
        DECODE: begin
          execEn_q <= 1'b1;
          state_q  <= EXEC;
        end
        EXEC: begin
          if (halt_req) begin
            halted_q <= 1'b1;
            state_q  <= HALT;
          end else begin
            state_q  <= FETCH;
          end
        end
        HALT: begin
          if (!halt_req) begin
            halted_q <= 1'b0;
            state_q  <= FETCH;
          end
        end
        FAULT: begin
          state_q <= FAULT;
        end
        default: begin
          memReq_q <= 1'b0;
          fault_q  <= 1'b1;
          state_q  <= FAULT;
        end
      endcase
    end
  end

  assign mem_req  = memReq_q;
  assign mem_addr = pcValue;
  assign instr    = instr_q;
  assign exec_en  = execEn_q;
  assign pc       = pcValue;
  assign halted   = halted_q;
  assign fault    = fault_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Self-checking bench for instr_sequencer: a memory responder, a condition-unit
// model driven from a scoreboard of expected instructions, and corner-case sequences.
module tb_instr_sequencer;
  import cpu_pkg::*;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       mem_req;
  logic [7:0] mem_addr;
  logic       mem_ack = 1'b0;
  logic [7:0] mem_rdata = 8'h00;
  logic [7:0] instr;
  logic       exec_en;
  logic       cond_taken = 1'b0;
  logic [7:0] branch_target = 8'h00;
  logic       halt_req = 1'b0;
  logic [7:0] pc;
  logic       halted;
  logic       fault;

  always #5 clock = ~clock;

  instr_sequencer #(
    .ADDR_W (8),
    .TIMEOUT(15)
  ) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .mem_req      (mem_req),
    .mem_addr     (mem_addr),
    .mem_ack      (mem_ack),
    .mem_rdata    (mem_rdata),
    .instr        (instr),
    .exec_en      (exec_en),
    .cond_taken   (cond_taken),
    .branch_target(branch_target),
    .halt_req     (halt_req),
    .pc           (pc),
    .halted       (halted),
    .fault        (fault)
  );

  typedef struct {
    logic [7:0] instrByte;
    logic       cond;
    logic [7:0] target;
    logic       halt;
    logic [7:0] expNext;
  } vec_t;

  typedef struct {
    logic [7:0] instrByte;
    logic [7:0] pcAt;
    logic       cond;
    logic [7:0] target;
    logic       halt;
    logic [7:0] expNext;
  } exp_t;

  exp_t       expQ[$];
  logic [7:0] fetchQ[$];
  int         execCycQ[$];
  logic [7:0] mem [256];

  int         checks = 0;
  int         errors = 0;
  int         cyc = 1;
  int         ackDelay = 0;
  int         waitCnt = 0;
  bit         ackEnable = 1'b1;
  bit         forceAck = 1'b0;
  bit         manualHalt = 1'b0;
  logic [7:0] forceData = 8'h00;
  logic       curHalt = 1'b0;
  bit         pendingPc = 1'b0;
  logic [7:0] expPcAfter = 8'h00;
  bit         prevExec = 1'b0;
  bit         prevReq = 1'b0;
  logic [7:0] fetchExp;
  exp_t       rec;
  logic [7:0] modelPc;
  vec_t       prog [7];
  vec_t       haltProg [5];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Places one instruction at the running address and queues what the DUT must do with it.
  task automatic applyStimulus(input vec_t v);
    exp_t e;
    mem[modelPc] = v.instrByte;
    e.instrByte  = v.instrByte;
    e.pcAt       = modelPc;
    e.cond       = v.cond;
    e.target     = v.target;
    e.halt       = v.halt;
    e.expNext    = v.expNext;
    expQ.push_back(e);
    fetchQ.push_back(modelPc);
    modelPc = v.expNext;
  endtask

  task automatic waitDrain(input int budget);
    int n = 0;
    while ((expQ.size() != 0 || pendingPc) && n < budget) begin
      @(negedge clock);
      n++;
    end
    checkOutput("drain", {31'd0, (expQ.size() == 0 && !pendingPc)}, 32'd1);
  endtask

  task automatic doReset();
    reset_n = 1'b0;
    expQ.delete();
    fetchQ.delete();
    execCycQ.delete();
    manualHalt = 1'b0;
    repeat (2) @(negedge clock);
  endtask

  always @(posedge clock) begin
    if (!reset_n) cyc = 1;
    else cyc++;
  end

  // Memory responder: answers a request after ackDelay wait cycles.
  always @(negedge clock) begin
    if (mem_req && !prevReq && fetchQ.size() != 0) begin
      fetchExp = fetchQ.pop_front();
      checkOutput("fetch_addr", {24'd0, mem_addr}, {24'd0, fetchExp});
    end
    prevReq = mem_req;
    if (mem_req && ackEnable) begin
      if (waitCnt >= ackDelay) begin
        mem_ack   = 1'b1;
        mem_rdata = mem[mem_addr];
      end else begin
        mem_ack = 1'b0;
        waitCnt++;
      end
    end else begin
      mem_ack = 1'b0;
      waitCnt = 0;
    end
    if (forceAck) begin
      mem_ack   = 1'b1;
      mem_rdata = forceData;
    end
  end

  // Execute monitor and condition-unit model.
  always @(negedge clock) begin
    if (!reset_n) begin
      curHalt   = 1'b0;
      pendingPc = 1'b0;
      prevExec  = 1'b0;
    end else begin
      if (pendingPc) begin
        checkOutput("pc_after_exec", {24'd0, pc}, {24'd0, expPcAfter});
        pendingPc = 1'b0;
      end
      if (exec_en) begin
        checkOutput("exec_single", {31'd0, prevExec}, 32'd0);
        execCycQ.push_back(cyc);
        checkOutput("exec_expected", {31'd0, (expQ.size() != 0)}, 32'd1);
        if (expQ.size() != 0) begin
          rec = expQ.pop_front();
          checkOutput("exec_instr", {24'd0, instr}, {24'd0, rec.instrByte});
          checkOutput("exec_pc", {24'd0, pc}, {24'd0, rec.pcAt});
          cond_taken    = rec.cond;
          branch_target = rec.target;
          curHalt       = rec.halt;
          expPcAfter    = rec.expNext;
          pendingPc     = 1'b1;
        end
      end
      prevExec = exec_en;
    end
    halt_req = curHalt | manualHalt;
  end

  initial begin
    int n;
    int reqCnt;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    reset_n = 1'b0;
    repeat (3) @(negedge clock);

    checkOutput("reset_mem_req", {31'd0, mem_req}, 32'd0);
    checkOutput("reset_exec_en", {31'd0, exec_en}, 32'd0);
    checkOutput("reset_instr", {24'd0, instr}, 32'd0);
    checkOutput("reset_pc", {24'd0, pc}, 32'd0);
    checkOutput("reset_halted", {31'd0, halted}, 32'd0);
    checkOutput("reset_fault", {31'd0, fault}, 32'd0);

    // Zero-wait program: sequential, branch taken/not taken, non-branch with cond high, wrap.
    prog[0] = '{8'h05, 1'b0, 8'h00, 1'b0, 8'h01};
    prog[1] = '{8'h40, 1'b1, 8'h77, 1'b0, 8'h02};
    prog[2] = '{8'hC1, 1'b1, 8'h20, 1'b0, 8'h20};
    prog[3] = '{8'hC1, 1'b0, 8'h55, 1'b0, 8'h21};
    prog[4] = '{8'h83, 1'b1, 8'h90, 1'b0, 8'h22};
    prog[5] = '{8'hC5, 1'b1, 8'hFF, 1'b0, 8'hFF};
    prog[6] = '{8'h3A, 1'b0, 8'h10, 1'b1, 8'h00};
    modelPc  = 8'h00;
    ackDelay = 0;
    for (int i = 0; i < 7; i++) applyStimulus(prog[i]);
    reset_n = 1'b1;
    waitDrain(200);
    checkOutput("exec_count", execCycQ.size(), 32'd7);
    checkOutput("exec_cycle_first", execCycQ[0], 32'd4);
    checkOutput("exec_cycle_second", execCycQ[1], 32'd8);
    checkOutput("prog_halted", {31'd0, halted}, 32'd1);
    repeat (4) begin
      @(negedge clock);
      checkOutput("halt_no_req", {31'd0, mem_req}, 32'd0);
      checkOutput("halt_pc_wrap", {24'd0, pc}, 32'd0);
    end

    // Ack on the last WAIT cycle before the timeout must still fetch.
    doReset();
    ackDelay = 14;
    modelPc  = 8'h00;
    applyStimulus('{8'h9C, 1'b0, 8'h00, 1'b1, 8'h01});
    reset_n = 1'b1;
    waitDrain(100);
    checkOutput("late_ack_cycle", execCycQ[0], 32'd18);
    checkOutput("late_ack_fault", {31'd0, fault}, 32'd0);
    checkOutput("late_ack_halted", {31'd0, halted}, 32'd1);

    // Ack withheld: fault after 15 wait cycles, then stuck until reset.
    doReset();
    ackEnable = 1'b0;
    fetchQ.push_back(8'h00);
    reset_n = 1'b1;
    reqCnt = 0;
    n = 0;
    while (!fault && n < 40) begin
      @(negedge clock);
      if (mem_req) reqCnt++;
      n++;
    end
    checkOutput("timeout_req_cycles", reqCnt, 32'd15);
    checkOutput("timeout_fault", {31'd0, fault}, 32'd1);
    checkOutput("timeout_req_low", {31'd0, mem_req}, 32'd0);
    forceData  = 8'hE7;
    forceAck   = 1'b1;
    manualHalt = 1'b1;
    repeat (6) begin
      @(negedge clock);
      checkOutput("fault_sticky", {31'd0, fault}, 32'd1);
      checkOutput("fault_no_req", {31'd0, mem_req}, 32'd0);
      checkOutput("fault_no_exec", {31'd0, exec_en}, 32'd0);
      checkOutput("fault_not_halted", {31'd0, halted}, 32'd0);
      checkOutput("fault_instr", {24'd0, instr}, 32'd0);
      checkOutput("fault_pc_frozen", {24'd0, pc}, 32'd0);
    end
    forceAck   = 1'b0;
    manualHalt = 1'b0;
    doReset();
    checkOutput("fault_reset_clear", {31'd0, fault}, 32'd0);
    checkOutput("fault_reset_pc", {24'd0, pc}, 32'd0);

    // Halt raised while instruction at pc=3 is waiting for memory.
    ackEnable = 1'b1;
    ackDelay  = 2;
    modelPc   = 8'h00;
    haltProg[0] = '{8'h11, 1'b0, 8'h00, 1'b0, 8'h01};
    haltProg[1] = '{8'h22, 1'b0, 8'h00, 1'b0, 8'h02};
    haltProg[2] = '{8'h33, 1'b0, 8'h00, 1'b0, 8'h03};
    haltProg[3] = '{8'h44, 1'b1, 8'h80, 1'b0, 8'h04};
    haltProg[4] = '{8'h55, 1'b0, 8'h00, 1'b0, 8'h05};
    for (int i = 0; i < 4; i++) applyStimulus(haltProg[i]);
    reset_n = 1'b1;
    n = 0;
    while (!(mem_req && mem_addr == 8'h03) && n < 100) begin
      @(negedge clock);
      n++;
    end
    checkOutput("halt_wait_seen", {31'd0, (mem_req && mem_addr == 8'h03)}, 32'd1);
    manualHalt = 1'b1;
    waitDrain(100);
    checkOutput("halt_state", {31'd0, halted}, 32'd1);
    checkOutput("halt_pc", {24'd0, pc}, 32'd4);
    repeat (4) begin
      @(negedge clock);
      checkOutput("halt_hold_req", {31'd0, mem_req}, 32'd0);
      checkOutput("halt_hold", {31'd0, halted}, 32'd1);
    end
    applyStimulus(haltProg[4]);
    fetchQ.push_back(modelPc);
    manualHalt = 1'b0;
    waitDrain(100);
    checkOutput("resume_halted", {31'd0, halted}, 32'd0);

    // Reset during WAIT: request drops at once and a stray ack is ignored.
    ackEnable = 1'b0;
    n = 0;
    while (!mem_req && n < 20) begin
      @(negedge clock);
      n++;
    end
    checkOutput("pre_reset_req", {31'd0, mem_req}, 32'd1);
    checkOutput("pre_reset_instr", {24'd0, instr}, 32'h55);
    @(posedge clock);
    #2;
    reset_n = 1'b0;
    expQ.delete();
    fetchQ.delete();
    forceData = 8'hAA;
    forceAck  = 1'b1;
    #1;
    checkOutput("async_req_drop", {31'd0, mem_req}, 32'd0);
    checkOutput("async_instr_clear", {24'd0, instr}, 32'd0);
    checkOutput("async_pc_clear", {24'd0, pc}, 32'd0);
    @(negedge clock);
    #1;
    reset_n = 1'b1;
    @(posedge clock);
    #2;
    forceAck = 1'b0;
    repeat (3) begin
      @(negedge clock);
      checkOutput("stray_ack_ignored", {24'd0, instr}, 32'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
